seg_value_formatter: RTL
========================

// Module: seg_value_formatter
// PURPOSE
// Upstream of the display/seven_segment multiplexer: converts a binary value into
// DIGITS packed 7-segment patterns ready for the scan stage. Sequential double-dabble
// BCD conversion (one shift per clock), then glyph encoding with optional
// leading-zero blanking and an over-range indication. Uses a valid/ready input handshake.
// PARAMETERS
// WIDTH   14  binary input width; one conversion shift per bit
// DIGITS  4   decimal digits produced; max displayable = 10**DIGITS-1
// PORTS
// clk       in   1           system clock, rising edge
// rst       in   1           asynchronous reset, active-high
// in_valid  in   1           in_value is offered this cycle
// in_value  in   WIDTH       unsigned binary value to display
// blank_en  in   1           1 = blank leading zeros; sampled with in_value
// in_ready  out  1           1 only in IDLE; a transfer happens when in_valid && in_ready
// busy      out  1           1 in SHIFT or ENCODE
// seg_bus   out  7*DIGITS    digit k at [7k+6:7k]; digit 0 = least significant
// out_valid out  1           one-cycle pulse when seg_bus takes a new value
// BEHAVIOUR
// - Reset is asynchronous, active-high. Reset values: state=IDLE, seg_bus=0 (all off),
//   out_valid=0, busy=0, in_ready=1 (combinational from IDLE), count=0, BCD=0.
// - Glyphs are active-high, bit order {a,b,c,d,e,f,g} = [6:0]:
//   0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B dash=01 blank=00 (hex).
// - FSM states:
//   IDLE: in_ready=1. On a transfer at edge N, latch in_value into the shift register,
//     latch blank_en, clear BCD, count=0, go to SHIFT. No transfer: hold seg_bus.
//   SHIFT: per edge, add 3 to every BCD nibble >=5, then shift {BCD,bin} left by 1.
//     count increments; after WIDTH shifts (edges N+1..N+WIDTH) go to ENCODE.
//   ENCODE: edge N+WIDTH+1 registers seg_bus, pulses out_valid=1 for the following
//     cycle, returns to IDLE. Latency, transfer edge to out_valid high: WIDTH+1 clocks.
// - BCD register is 4*DIGITS+4 bits wide. If any nibble above DIGITS-1 is nonzero
//   (value > 10**DIGITS-1), every digit shows dash.
// - Blanking: when blank_en is set, leading-zero digits above digit 0 are blank.
//   Digit 0 is never blanked, so value 0 shows "0".
// - in_valid while busy: ignored. No queueing, and the latched value is not disturbed.
//   in_value and blank_en changes during the conversion have no effect.
// - A transfer is accepted in the cycle the FSM returns to IDLE (the out_valid cycle).
//   Back-to-back throughput is one result per WIDTH+2 clocks.
// - Reset during SHIFT/ENCODE: aborts immediately with all reset values. seg_bus goes
//   to 0 and no out_valid is produced for the aborted value.
// - seg_bus is held stable between out_valid pulses. The downstream scanner may sample
//   it at any time.
// TESTING
// - Reset, then idle 20 clks -> seg_bus=0, out_valid never 1, in_ready=1, busy=0.
// - in_value=1234, blank_en=0 -> after 15 clks out_valid pulses once;
//   seg_bus={30,6D,79,33}.
// - in_value=7, blank_en=1 -> seg_bus={00,00,00,70}. in_value=0, blank_en=1 ->
//   {00,00,00,7E}. in_value=0, blank_en=0 -> {7E,7E,7E,7E}.
// - in_value=9999 -> {7B,7B,7B,7B}. in_value=10000 and in_value=16383 -> all digits 01.
// - Hold in_valid=1 with 42 then 99 during busy -> only 42 is converted. 99 is accepted
//   on the out_valid cycle, and its result follows WIDTH+2 clks later.
// - Assert rst at SHIFT count 6 -> seg_bus=0 and in_ready=1 at once. After release,
//   no out_valid occurs until a new transfer.

Source files
------------

// File: rtl/seg_value_formatter.sv
// seg_value_formatter
// Turns an unsigned binary value into DIGITS packed 7-segment glyphs for the
// display scanner. A sequential double-dabble converts one bit per clock.
// The BCD result is then encoded into glyphs, with optional leading-zero
// blanking and an all-dash pattern for values that do not fit.
module seg_value_formatter #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_value,
  input  logic                  blank_en,
  output logic                  in_ready,
  output logic                  busy,
  output logic [7*DIGITS-1:0]   seg_bus,
  output logic                  out_valid
);

  localparam int BCDW = 4*DIGITS + 4;
  localparam int CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_SHIFT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ENCODE
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  bin_reg;
  logic [BCDW-1:0]   bcd;
  logic [BCDW-1:0]   bcd_adj;
  logic [CW-1:0]     count;
  logic              blank_reg;
  logic              carry_lost;
  logic [7*DIGITS-1:0] seg_next;
  logic              over_range;
  logic              leading;
  logic [3:0]        digit;

  // Active-high glyph lookup, bit order {a,b,c,d,e,f,g}; non-decimal codes show a dash
  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'h7E;
      4'd1:    glyph = 7'h30;
      4'd2:    glyph = 7'h6D;
      4'd3:    glyph = 7'h79;
      4'd4:    glyph = 7'h33;
      4'd5:    glyph = 7'h5B;
      4'd6:    glyph = 7'h5F;
      4'd7:    glyph = 7'h70;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h7B;
      default: glyph = 7'h01;
    endcase
  endfunction

  // The handshake is only open while idle; everything else counts as busy
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Double-dabble correction: every nibble of 5 or more gets +3 before the shift
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < DIGITS + 1; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end else begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4];
      end
    end
  end

  // Glyph encoding of the finished BCD value, walking from the top digit down so
  // blanking stops at the first nonzero digit; digit 0 is always drawn
  always_comb begin
    seg_next   = '0;
    digit      = '0;
    leading    = blank_reg;
    over_range = carry_lost | (|bcd[BCDW-1:4*DIGITS]);
    for (int k = DIGITS - 1; k >= 0; k--) begin
      digit = bcd[4*k +: 4];
      if (over_range) begin
        seg_next[7*k +: 7] = 7'h01;
      end else if (leading && (k != 0) && (digit == 4'd0)) begin
        seg_next[7*k +: 7] = 7'h00;
      end else begin
        seg_next[7*k +: 7] = glyph(digit);
        leading = 1'b0;
      end
    end
  end

  // Control FSM: latch on a transfer, shift WIDTH times, then publish the glyphs
  // with a one-cycle out_valid pulse. A carry out of the top nibble is kept
  // sticky so that a value too large even for the guard nibble still reads as over-range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bin_reg    <= '0;
      bcd        <= '0;
      count      <= '0;
      blank_reg  <= 1'b0;
      carry_lost <= 1'b0;
      seg_bus    <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            bin_reg    <= in_value;
            blank_reg  <= blank_en;
            bcd        <= '0;
            carry_lost <= 1'b0;
            count      <= '0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          bcd        <= {bcd_adj[BCDW-2:0], bin_reg[WIDTH-1]};
          bin_reg    <= {bin_reg[WIDTH-2:0], 1'b0};
          carry_lost <= carry_lost | bcd_adj[BCDW-1];
          count      <= count + 1'b1;
          if (count == LAST_SHIFT) begin
            state <= ENCODE;
          end
        end
        ENCODE: begin
          seg_bus   <= seg_next;
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
